// File: rtl/inst_queue_way0_if.sv
// ----------------------------------------------------------------------------
// inst_queue_way0_if
// Purpose : Groups the fetch-side and decode-side handshake signals of the way0
//           instruction queue into one bundle.
// Signals :
//   jumpFlag_i             - redirect/flush request (into the queue)
//   valid_i/inst_i/instAddr_i/ready_o   - fetch side (push)
//   valid_o/inst_o/instAddr_o/ready_i   - decode side (pop)
//   count_o                - current occupancy, 0..DEPTH
// Modports: slave  - the queue itself
//           master - the environment driving it (fetch + decode + jump)
// ----------------------------------------------------------------------------
interface inst_queue_way0_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              jumpFlag_i;
    logic              valid_i;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] instAddr_i;
    logic              ready_o;
    logic              valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] instAddr_o;
    logic              ready_i;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  jumpFlag_i,
        input  valid_i,
        input  inst_i,
        input  instAddr_i,
        output ready_o,
        output valid_o,
        output inst_o,
        output instAddr_o,
        input  ready_i,
        output count_o
    );

    modport master (
        output jumpFlag_i,
        output valid_i,
        output inst_i,
        output instAddr_i,
        input  ready_o,
        input  valid_o,
        input  inst_o,
        input  instAddr_o,
        output ready_i,
        input  count_o
    );
endinterface

// File: rtl/inst_queue_way0.sv
// ----------------------------------------------------------------------------
// inst_queue_way0
// Purpose : Small FIFO of {instAddr, inst} pairs between the way0 fetch stage
//           and the way0 decoder. A jump flushes the queue so that no
//           wrong-path instruction reaches decode.
// Ports   :
//   clk      - core clock, rising edge
//   reset_n  - asynchronous active-low reset
//   q_if     - inst_queue_way0_if.slave handshake bundle (fetch, decode, jump,
//              occupancy)
// ----------------------------------------------------------------------------
module inst_queue_way0 #(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic                clk,
    input  logic                reset_n,
    inst_queue_way0_if.slave    q_if
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // No push-through when full: ready depends only on registered count, so a
    // same-cycle pop does not reopen space until the following cycle.
    assign w_ready = !w_full && !q_if.jumpFlag_i;
    assign w_valid = !w_empty && !q_if.jumpFlag_i;
    assign w_push  = q_if.valid_i && w_ready;
    assign w_pop   = w_valid && q_if.ready_i;

    // Pointers and occupancy. A jump resets them but leaves storage intact;
    // stale entries are unreachable once count is zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (q_if.jumpFlag_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage; w_push is already blocked during a jump.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_addr_mem[r_wr_ptr] <= q_if.instAddr_i;
            r_inst_mem[r_wr_ptr] <= q_if.inst_i;
        end
    end

    assign q_if.ready_o    = w_ready;
    assign q_if.valid_o    = w_valid;
    assign q_if.count_o    = r_count;
    assign q_if.inst_o     = w_empty ? NOP_INST : r_inst_mem[r_rd_ptr];
    assign q_if.instAddr_o = w_empty ? '0 : r_addr_mem[r_rd_ptr];

endmodule

// File: tb/tb_inst_queue_way0.sv
module tb_inst_queue_way0;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk;
    logic reset_n;

    inst_queue_way0_if #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) bus ();

    inst_queue_way0 #(
        .DEPTH   (DEPTH),
        .ADDR_W  (32),
        .INST_W  (32),
        .NOP_INST(NOP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .q_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents of the queue, head at index 0, {addr, inst}.
    logic [63:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic jf, output logic ev, output logic er);
        int n;
        n  = mq.size();
        ev = (n != 0) && !jf;
        er = (n != DEPTH) && !jf;
        chk("valid_o", 64'(bus.valid_o), 64'(ev));
        chk("ready_o", 64'(bus.ready_o), 64'(er));
        chk("count_o", 64'(bus.count_o), 64'(n));
        chk("inst_o", 64'(bus.inst_o), (n == 0) ? 64'(NOP) : 64'(mq[0][31:0]));
        chk("instAddr_o", 64'(bus.instAddr_o), (n == 0) ? 64'd0 : 64'(mq[0][63:32]));
    endtask

    // One clock cycle: entered at posedge+1, drive, check, advance, update model.
    task automatic cycle(input logic jf, input logic vi, input logic [31:0] ai,
                         input logic [31:0] ii, input logic ri);
        logic ev, er, epush, epop;
        bus.jumpFlag_i = jf;
        bus.valid_i    = vi;
        bus.instAddr_i = ai;
        bus.inst_i     = ii;
        bus.ready_i    = ri;
        #3;
        check_outputs(jf, ev, er);
        epush = vi && er;
        epop  = ev && ri;
        @(posedge clk);
        #1;
        if (jf) begin
            mq.delete();
        end else begin
            if (epop) void'(mq.pop_front());
            if (epush) mq.push_back({ai, ii});
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic ev, er;
        reset_n        = 1'b0;
        bus.jumpFlag_i = 1'b0;
        bus.valid_i    = 1'b0;
        bus.instAddr_i = '0;
        bus.inst_i     = '0;
        bus.ready_i    = 1'b0;

        // Reset state
        #12;
        check_outputs(1'b0, ev, er);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push, fall-through in one cycle, popped immediately
        cycle(1'b0, 1'b1, 32'h80000000, 32'h00100093, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        // Fill with decoder stalled, try a 5th push, then drain
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h80000000 + 32'(4 * i), 32'h00200013 + 32'(i << 20), 1'b0);
        cycle(1'b0, 1'b1, 32'h80000010, 32'hdeadbeef, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        // Full with simultaneous push and pop: only the pop happens
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h80000100 + 32'(4 * i), 32'h11110000 + 32'(i), 1'b0);
        cycle(1'b0, 1'b1, 32'h80000200, 32'h22220000, 1'b1);
        cycle(1'b0, 1'b1, 32'h80000200, 32'h22220000, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        // 12 back-to-back pushes with continuous pop; pointers wrap
        for (int i = 0; i < 12; i++)
            cycle(1'b0, 1'b1, 32'h80000300 + 32'(4 * i), 32'h33330000 + 32'(i), 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        // Three entries then a one-cycle jump while both sides are active
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 32'h80000400 + 32'(4 * i), 32'h44440000 + 32'(i), 1'b0);
        cycle(1'b1, 1'b1, 32'h80000500, 32'h55550000, 1'b1);
        cycle(1'b0, 1'b1, 32'h80001000, 32'h66660000, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        // Multi-cycle jump keeps the queue blocked
        cycle(1'b0, 1'b1, 32'h80001100, 32'h77770000, 1'b0);
        cycle(1'b1, 1'b1, 32'h80001104, 32'h77770001, 1'b1);
        cycle(1'b1, 1'b1, 32'h80001108, 32'h77770002, 1'b1);
        cycle(1'b0, 1'b1, 32'h8000110c, 32'h77770003, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();

        // Asynchronous reset mid-cycle with two entries held
        cycle(1'b0, 1'b1, 32'h80002000, 32'h88880000, 1'b0);
        cycle(1'b0, 1'b1, 32'h80002004, 32'h88880001, 1'b0);
        bus.valid_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        check_outputs(1'b0, ev, er);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(99) < 5) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                  $urandom(), $urandom(),
                  ($urandom_range(99) < 55) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
